// File: rtl/axis_hdr_pkg.sv
// axis_hdr_pkg: shared state encoding and byte-count helpers for the header inserter
package axis_hdr_pkg;
  typedef enum logic [1:0] {IDLE, HDR, BODY, TAIL} state_e;
  localparam int MAXB = 64;
  function automatic int bytes_of(input int wd);
    return wd / 8;
  endfunction
  function automatic int popcnt(input logic [MAXB-1:0] k);
    int c;
    c = 0;
    for (int i = 0; i < MAXB; i++) c += 32'(k[i]);
    return c;
  endfunction
  function automatic logic [MAXB-1:0] left_keep(input int n, input int bw);
    logic [MAXB-1:0] m;
    m = '0;
    for (int i = 0; i < MAXB; i++) m[i] = (i < bw) && (i + n >= bw);
    return m;
  endfunction
endpackage

// File: rtl/axis_byte_packer.sv
// axis_byte_packer: appends a masked beat behind the left-aligned residual bytes
module axis_byte_packer import axis_hdr_pkg::*; #(
  parameter int BW = 4,
  parameter int CW = 3
) (
  input  logic [8*BW-1:0] res_i,
  input  logic [CW-1:0]   rcnt_i,
  input  logic [8*BW-1:0] data_i,
  input  logic [BW-1:0]   keep_i,
  output logic [8*BW-1:0] beat_o,
  output logic [8*BW-1:0] rem_o,
  output logic [CW:0]     tot_o
);
  logic [8*BW-1:0] dm;
  logic [16*BW-1:0] cat;
  for (genvar b = 0; b < BW; b++) begin : g_m
    assign dm[8*b +: 8] = data_i[8*b +: 8] & {8{keep_i[b]}};
  end
  // bytes past the valid count stay zero so the residual can be OR-merged
  assign cat = {res_i, {8*BW{1'b0}}} | ({dm, {8*BW{1'b0}}} >> (8*rcnt_i));
  assign {beat_o, rem_o} = cat;
  assign tot_o = {1'b0, rcnt_i} + (CW+1)'(popcnt(MAXB'(keep_i)));
endmodule

// File: rtl/axi_stream_insert_header_mb.sv
// axi_stream_insert_header_mb: prepends a 0..HDR_BEATS-beat header and repacks the stream densely
module axi_stream_insert_header_mb import axis_hdr_pkg::*; #(
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = bytes_of(DATA_WD),
  parameter int HDR_BEATS = 2,
  parameter int HDR_WD = HDR_BEATS*DATA_WD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [HDR_WD-1:0]       header_insert,
  input  logic [HDR_WD/8-1:0]     keep_insert,
  output logic                    ready_insert
);
  localparam int BW = DATA_BYTE_WD;
  localparam int HB = HDR_WD/8;
  localparam int CW = $clog2(BW+1);
  localparam int HCW = $clog2(HB+1);
  localparam logic [HCW-1:0] BWH = HCW'(BW);
  localparam logic [CW:0] BWT = (CW+1)'(BW);
  state_e st_q, st_d;
  logic [HDR_WD-1:0] hdr_q, hdr_d, hal, hsrc, hrem;
  logic [HCW-1:0] hcnt_q, hcnt_d, n, hn, hrn;
  logic [DATA_WD-1:0] res_q, res_d, data_q, data_d, beat, rem;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [CW:0] tot;
  logic [BW-1:0] keep_q, keep_d;
  logic last_q, last_d, valid_q, valid_d, free, hdr_fire, in_fire, fin;
  assign free = !valid_q || ready_out;
  assign ready_insert = rst_n && st_q == IDLE && free;
  assign ready_in = rst_n && st_q == BODY && free;
  assign hdr_fire = valid_insert && ready_insert;
  assign in_fire = valid_in && ready_in;
  assign n = HCW'(popcnt(MAXB'(keep_insert)));
  // left-align the n valid header bytes; unused upper bytes shift out
  assign hal = header_insert << (8*(HB - int'(n)));
  assign hsrc = st_q == IDLE ? hal : hdr_q;
  assign hn = st_q == IDLE ? n : hcnt_q;
  assign hrem = hn >= BWH ? hsrc << DATA_WD : hsrc;
  assign hrn = hn >= BWH ? hn - BWH : hn;
  assign fin = last_in && tot <= BWT;
  axis_byte_packer #(.BW(BW), .CW(CW)) u_pack (
    .res_i(res_q),
    .rcnt_i(rcnt_q),
    .data_i(data_in),
    .keep_i(keep_in),
    .beat_o(beat),
    .rem_o(rem),
    .tot_o(tot)
  );
  always_comb begin
    st_d = st_q;
    hdr_d = hdr_q;
    hcnt_d = hcnt_q;
    res_d = res_q;
    rcnt_d = rcnt_q;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    valid_d = valid_q && !ready_out;
    if ((st_q == IDLE && hdr_fire) || (st_q == HDR && free)) begin
      if (hn >= BWH) begin
        valid_d = 1'b1;
        data_d = hsrc[HDR_WD-1 -: DATA_WD];
        keep_d = '1;
        last_d = 1'b0;
      end
      st_d = hrn >= BWH ? HDR : BODY;
      hdr_d = hrem;
      hcnt_d = hrn;
      res_d = hrem[HDR_WD-1 -: DATA_WD];
      rcnt_d = CW'(hrn);
    end else if (in_fire) begin
      valid_d = 1'b1;
      data_d = beat;
      keep_d = fin ? BW'(left_keep(int'(tot), BW)) : '1;
      last_d = fin;
      st_d = !last_in ? BODY : fin ? IDLE : TAIL;
      res_d = fin ? '0 : rem;
      rcnt_d = fin ? '0 : CW'(tot - BWT);
    end else if (st_q == TAIL && free) begin
      valid_d = 1'b1;
      data_d = res_q;
      keep_d = BW'(left_keep(int'(rcnt_q), BW));
      last_d = 1'b1;
      st_d = IDLE;
      res_d = '0;
      rcnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= IDLE;
      hdr_q <= '0;
      hcnt_q <= '0;
      res_q <= '0;
      rcnt_q <= '0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      st_q <= st_d;
      hdr_q <= hdr_d;
      hcnt_q <= hcnt_d;
      res_q <= res_d;
      rcnt_q <= rcnt_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
      valid_q <= valid_d;
    end
  end
  assign valid_out = valid_q;
  assign data_out = data_q;
  assign keep_out = keep_q;
  assign last_out = last_q;
endmodule

// File: tb/tb_axi_stream_insert_header_mb.sv
// tb_axi_stream_insert_header_mb: directed and randomized checks against a byte-queue reference model
module tb_axi_stream_insert_header_mb;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int HB = 8;
  typedef logic [7:0] u8;
  typedef struct { logic [DW-1:0] d; logic [BW-1:0] k; logic l; } beat_t;
  typedef struct { logic [63:0] h; logic [7:0] k; } hdr_t;
  logic clk = 0, rst_n = 0, valid_in = 0, last_in = 0, valid_insert = 0, ready_out = 0;
  logic [DW-1:0] data_in = '0;
  logic [BW-1:0] keep_in = '0;
  logic [63:0] header_insert = '0;
  logic [7:0] keep_insert = '0;
  logic ready_in, valid_out, last_out, ready_insert;
  logic [DW-1:0] data_out;
  logic [BW-1:0] keep_out;
  int errors = 0, checks = 0, hdr_done = 0, pkt_done = 0;
  bit stall_prev = 0;
  logic [DW+BW:0] prev;
  u8 pb[$];
  hdr_t hd_q[$];
  beat_t pl_q[$], exp_q[$];

  axi_stream_insert_header_mb dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .header_insert(header_insert), .keep_insert(keep_insert), .ready_insert(ready_insert)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // source side: header word plus payload split into beats, keep left-aligned on the last one
  task automatic push_pkt(input logic [63:0] h, input int n, input bit zl);
    hdr_t ht;
    beat_t bt;
    int nb, c;
    nb = pb.size();
    ht.h = h;
    ht.k = 8'((1 << n) - 1);
    hd_q.push_back(ht);
    for (int b = 0; b < nb; b += BW) begin
      c = (nb - b < BW) ? nb - b : BW;
      bt.d = '0;
      for (int j = 0; j < c; j++) bt.d[DW-1-8*j -: 8] = pb[b+j];
      bt.k = 4'(((1 << c) - 1) << (BW - c));
      bt.l = !zl && (b + BW >= nb);
      pl_q.push_back(bt);
    end
    if (zl) begin
      bt.d = '0;
      bt.k = '0;
      bt.l = 1'b1;
      pl_q.push_back(bt);
    end
  endtask

  // reference: concatenate header and payload bytes, cut into BW-byte beats
  task automatic model(input logic [63:0] h, input int n, input bit zl);
    u8 s[$];
    beat_t bt;
    int t, nbt, c;
    bit extra;
    for (int i = n - 1; i >= 0; i--) s.push_back(h[8*i +: 8]);
    foreach (pb[i]) s.push_back(pb[i]);
    t = s.size();
    nbt = (t + BW - 1) / BW;
    extra = zl && (t % BW == 0);
    for (int b = 0; b < nbt; b++) begin
      c = (t - b*BW < BW) ? t - b*BW : BW;
      bt.d = '0;
      for (int j = 0; j < c; j++) bt.d[DW-1-8*j -: 8] = s[b*BW+j];
      bt.k = 4'(((1 << c) - 1) << (BW - c));
      bt.l = (b == nbt - 1) && !extra;
      exp_q.push_back(bt);
    end
    if (extra) begin
      bt.d = '0;
      bt.k = '0;
      bt.l = 1'b1;
      exp_q.push_back(bt);
    end
  endtask

  task automatic ex(input logic [DW-1:0] d, input logic [BW-1:0] k, input bit l);
    beat_t bt;
    bt.d = d;
    bt.k = k;
    bt.l = l;
    exp_q.push_back(bt);
  endtask

  task automatic ex_t1();
    ex(32'hEEDDCCAA, 4'b1111, 0);
    ex(32'hBBCCDDEE, 4'b1111, 0);
    ex(32'hFF001122, 4'b1111, 0);
    ex(32'h33445566, 4'b1111, 0);
    ex(32'h77889900, 4'b1111, 0);
    ex(32'hAA000000, 4'b1000, 1);
  endtask

  task automatic rand_pkt();
    int n, nb;
    bit zl;
    logic [63:0] h;
    n = $urandom_range(HB);
    zl = ($urandom_range(5) == 0);
    nb = zl ? BW * $urandom_range(0, 4) : $urandom_range(1, 20);
    pb.delete();
    for (int i = 0; i < nb; i++) pb.push_back(u8'($urandom));
    h = {$urandom, $urandom};
    push_pkt(h, n, zl);
    model(h, n, zl);
  endtask

  task automatic run(input int sp, input int rp, input int budget, input bit must);
    int cyc;
    bit hf, pf, of;
    beat_t e;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!valid_insert && hd_q.size() != 0 && $urandom_range(99) < sp) begin
        valid_insert = 1;
        header_insert = hd_q[0].h;
        keep_insert = hd_q[0].k;
      end
      if (!valid_in && pl_q.size() != 0 && $urandom_range(99) < sp) begin
        valid_in = 1;
        data_in = pl_q[0].d;
        keep_in = pl_q[0].k;
        last_in = pl_q[0].l;
      end
      ready_out = $urandom_range(99) < rp;
      #1;
      if (stall_prev) chk("hold", {valid_out, data_out, keep_out, last_out}, {1'b1, prev});
      stall_prev = valid_out && !ready_out;
      prev = {data_out, keep_out, last_out};
      hf = valid_insert && ready_insert;
      pf = valid_in && ready_in;
      of = valid_out && ready_out;
      if (hf) chk("hdr_idle", hdr_done, pkt_done);
      if (of) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat", {data_out, keep_out, last_out}, {e.d, e.k, e.l});
        end
      end
      @(posedge clk);
      #1;
      if (hf) begin
        void'(hd_q.pop_front());
        valid_insert = 0;
        hdr_done++;
      end
      if (pf) begin
        if (pl_q[0].l) pkt_done++;
        void'(pl_q.pop_front());
        valid_in = 0;
      end
    end
    if (must) chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_keep", keep_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_rdy_in", ready_in, 0);
    chk("rst_rdy_hdr", ready_insert, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_rdy_hdr", ready_insert, 1);
    chk("idle_rdy_in", ready_in, 0);
    pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11, 8'h22,
           8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h00, 8'hAA};
    push_pkt(64'h12345678FFEEDDCC, 3, 0);
    ex_t1();
    run(100, 100, 200, 1);
    push_pkt(64'h0123456789ABCDEF, 0, 0);
    ex(32'hAABBCCDD, 4'b1111, 0);
    ex(32'hEEFF0011, 4'b1111, 0);
    ex(32'h22334455, 4'b1111, 0);
    ex(32'h66778899, 4'b1111, 0);
    ex(32'h00AA0000, 4'b1100, 1);
    run(100, 100, 200, 1);
    pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_pkt(64'h1122334455667788, 6, 0);
    ex(32'h33445566, 4'b1111, 0);
    ex(32'h7788AABB, 4'b1111, 0);
    ex(32'hCCDD0000, 4'b1100, 1);
    run(100, 100, 200, 1);
    pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11, 8'h22,
           8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h00, 8'hAA};
    push_pkt(64'hFFEEDDCC, 3, 0);
    ex_t1();
    run(100, 50, 400, 1);
    for (int p = 0; p < 6; p++) rand_pkt();
    run(100, 100, 2000, 1);
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 8; p++) rand_pkt();
      run($urandom_range(40, 100), $urandom_range(30, 100), 4000, 1);
    end
    pb.delete();
    for (int i = 0; i < 40; i++) pb.push_back(u8'($urandom));
    push_pkt(64'hA1B2C3D4E5F60718, 3, 0);
    model(64'hA1B2C3D4E5F60718, 3, 0);
    run(100, 100, 6, 0);
    @(negedge clk);
    rst_n = 0;
    valid_in = 0;
    valid_insert = 0;
    hd_q.delete();
    pl_q.delete();
    exp_q.delete();
    stall_prev = 0;
    hdr_done = 0;
    pkt_done = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_last", last_out, 0);
    chk("midrst_rdy_hdr", ready_insert, 0);
    chk("midrst_rdy_in", ready_in, 0);
    rst_n = 1;
    pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_pkt(64'h1122334455667788, 6, 0);
    ex(32'h33445566, 4'b1111, 0);
    ex(32'h7788AABB, 4'b1111, 0);
    ex(32'hCCDD0000, 4'b1100, 1);
    run(100, 100, 200, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
